// File: rtl/branch_exec_unit.sv
// Branch/jump resolution stage: evaluates the branch condition, computes the
// corrected fetch address and predictor updates, and presents them through a 1-deep result register.
module branch_exec_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5,
   parameter int CTR_W = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [WIDTH-1:0] targetAddress,
   input  logic [WIDTH-1:0] nxtPC,
   input  logic [WIDTH-1:0] predictedPC,
   input  logic             isJAL,
   input  logic             isJALR,
   input  logic [2:0]       funct3,
   input  logic [CTR_W-1:0] state,
   input  logic             redirect,
   input  logic [TAG_W-1:0] tagIn,
   output logic             outValid,
   input  logic             outReady,
   output logic [TAG_W-1:0] tagOut,
   output logic [WIDTH-1:0] correctAddress,
   output logic [WIDTH-1:0] branchResult,
   output logic [CTR_W-1:0] nextState,
   output logic             reset,
   output logic             takenBranch,
   output logic             writeBTB,
   output logic             btbValid,
   output logic             updatePHT,
   input  logic             perfClear,
   output logic [CNT_W-1:0] branchCount,
   output logic [CNT_W-1:0] mispredictCount
);

   logic             accept;
   logic             is_cond, is_jal, is_jalr, is_inval;
   logic             br_taken;
   logic [WIDTH-1:0] jalr_sum;
   logic [WIDTH-1:0] fetched_pc;
   logic [WIDTH-1:0] calc_addr;
   logic [CTR_W-1:0] calc_state;
   logic             calc_reset, calc_taken, calc_wbtb, calc_bval;

   assign inReady = !outValid || outReady;
   assign accept  = inValid && inReady && !flush;

   always_comb begin
      is_cond  = !isJAL && !isJALR;
      is_jal   = isJAL && !isJALR;
      is_jalr  = isJALR && !isJAL;
      is_inval = isJAL && isJALR;

      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = (src1 == src2);
         3'b001:  br_taken = (src1 != src2);
         3'b100:  br_taken = ($signed(src1) <  $signed(src2));
         3'b101:  br_taken = ($signed(src1) >= $signed(src2));
         3'b110:  br_taken = (src1 <  src2);
         3'b111:  br_taken = (src1 >= src2);
         default: br_taken = 1'b0;
      endcase

      jalr_sum   = src1 + src2;
      fetched_pc = redirect ? predictedPC : nxtPC;

      calc_addr  = nxtPC;
      calc_taken = 1'b0;
      calc_wbtb  = 1'b0;
      calc_state = state;
      if (is_jal) begin
         calc_addr  = targetAddress;
         calc_taken = 1'b1;
      end else if (is_jalr) begin
         calc_addr  = {jalr_sum[WIDTH-1:1], 1'b0};
         calc_taken = 1'b1;
         calc_wbtb  = 1'b1;
      end else if (is_cond) begin
         calc_addr  = br_taken ? targetAddress : nxtPC;
         calc_taken = br_taken;
         calc_wbtb  = br_taken || redirect;
         if (br_taken)
            calc_state = (state == '1) ? state : state + CTR_W'(1);
         else
            calc_state = (state == '0) ? state : state - CTR_W'(1);
      end

      calc_reset = !is_inval && (calc_addr != fetched_pc);
      calc_bval  = !(is_cond && !br_taken && redirect);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         outValid       <= 1'b0;
         tagOut         <= '0;
         correctAddress <= '0;
         branchResult   <= '0;
         nextState      <= '0;
         reset          <= 1'b0;
         takenBranch    <= 1'b0;
         writeBTB       <= 1'b0;
         btbValid       <= 1'b0;
         updatePHT      <= 1'b0;
      end else begin
         // flush only drops the valid bit; result fields keep their last value
         if (flush)
            outValid <= 1'b0;
         else if (accept)
            outValid <= 1'b1;
         else if (outReady)
            outValid <= 1'b0;

         if (accept) begin
            tagOut         <= tagIn;
            correctAddress <= calc_addr;
            branchResult   <= nxtPC;
            nextState      <= calc_state;
            reset          <= calc_reset;
            takenBranch    <= calc_taken;
            writeBTB       <= calc_wbtb;
            btbValid       <= calc_bval;
            updatePHT      <= is_cond;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || perfClear) begin
         branchCount     <= '0;
         mispredictCount <= '0;
      end else begin
         if (accept && is_cond && branchCount != '1)
            branchCount <= branchCount + CNT_W'(1);
         if (accept && calc_reset && mispredictCount != '1)
            mispredictCount <= mispredictCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_exec_unit.sv
// Directed plus randomized checks of branch_exec_unit against a behavioural
// model of the result register, predictor update and performance counters.
module tb_branch_exec_unit;

   localparam int W   = 32;
   localparam int TW  = 5;
   localparam int CW  = 2;
   localparam int NW  = 16;
   localparam int CW2 = 3;
   localparam int NW2 = 2;

   logic clk = 1'b0;
   logic reset_n, flush, inValid, outReady, isJAL, isJALR, redirect, perfClear;
   logic [W-1:0]   src1, src2, targetAddress, nxtPC, predictedPC;
   logic [2:0]     funct3;
   logic [CW-1:0]  state;
   logic [CW2-1:0] state2;
   logic [TW-1:0]  tagIn;

   logic           inReady, outValid, rst_flag, takenBranch, writeBTB, btbValid, updatePHT;
   logic [TW-1:0]  tagOut;
   logic [W-1:0]   correctAddress, branchResult;
   logic [CW-1:0]  nextState;
   logic [NW-1:0]  branchCount, mispredictCount;

   logic           d2_inReady, d2_outValid, d2_reset, d2_taken, d2_wbtb, d2_bval, d2_upd;
   logic [TW-1:0]  d2_tag;
   logic [W-1:0]   d2_ca, d2_br;
   logic [CW2-1:0] d2_ns;
   logic [NW2-1:0] d2_bc, d2_mc;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic     m_valid, m_rst, m_tk, m_wb, m_bv, m_up;
   logic [TW-1:0] m_tag;
   logic [W-1:0]  m_ca, m_br;
   int       m_ns, m2_ns, m_bc, m_mc, m2_bc, m2_mc;

   always #5 clk = ~clk;

   branch_exec_unit dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .inValid(inValid), .inReady(inReady),
      .src1(src1), .src2(src2), .targetAddress(targetAddress), .nxtPC(nxtPC),
      .predictedPC(predictedPC), .isJAL(isJAL), .isJALR(isJALR), .funct3(funct3),
      .state(state), .redirect(redirect), .tagIn(tagIn), .outValid(outValid),
      .outReady(outReady), .tagOut(tagOut), .correctAddress(correctAddress),
      .branchResult(branchResult), .nextState(nextState), .reset(rst_flag),
      .takenBranch(takenBranch), .writeBTB(writeBTB), .btbValid(btbValid),
      .updatePHT(updatePHT), .perfClear(perfClear), .branchCount(branchCount),
      .mispredictCount(mispredictCount)
   );

   branch_exec_unit #(.WIDTH(W), .TAG_W(TW), .CTR_W(CW2), .CNT_W(NW2)) dut2 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .inValid(inValid), .inReady(d2_inReady),
      .src1(src1), .src2(src2), .targetAddress(targetAddress), .nxtPC(nxtPC),
      .predictedPC(predictedPC), .isJAL(isJAL), .isJALR(isJALR), .funct3(funct3),
      .state(state2), .redirect(redirect), .tagIn(tagIn), .outValid(d2_outValid),
      .outReady(outReady), .tagOut(d2_tag), .correctAddress(d2_ca),
      .branchResult(d2_br), .nextState(d2_ns), .reset(d2_reset),
      .takenBranch(d2_taken), .writeBTB(d2_wbtb), .btbValid(d2_bval),
      .updatePHT(d2_upd), .perfClear(perfClear), .branchCount(d2_bc),
      .mispredictCount(d2_mc)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat_step(input int v, input bit up, input int width);
      int mx = (1 << width) - 1;
      if (up) return (v < mx) ? v + 1 : v;
      return (v > 0) ? v - 1 : 0;
   endfunction

   task automatic model_zero();
      m_valid = 0; m_rst = 0; m_tk = 0; m_wb = 0; m_bv = 0; m_up = 0;
      m_tag = '0; m_ca = '0; m_br = '0; m_ns = 0; m2_ns = 0;
      m_bc = 0; m_mc = 0; m2_bc = 0; m2_mc = 0;
   endtask

   task automatic check_all();
      chk("outValid", outValid, m_valid);
      chk("tagOut", tagOut, m_tag);
      chk("correctAddress", correctAddress, m_ca);
      chk("branchResult", branchResult, m_br);
      chk("nextState", nextState, m_ns);
      chk("reset", rst_flag, m_rst);
      chk("takenBranch", takenBranch, m_tk);
      chk("writeBTB", writeBTB, m_wb);
      chk("btbValid", btbValid, m_bv);
      chk("updatePHT", updatePHT, m_up);
      chk("branchCount", branchCount, m_bc);
      chk("mispredictCount", mispredictCount, m_mc);
      chk("d2_outValid", d2_outValid, m_valid);
      chk("d2_nextState", d2_ns, m2_ns);
      chk("d2_branchCount", d2_bc, m2_bc);
      chk("d2_mispredictCount", d2_mc, m2_mc);
   endtask

   // One clock: check handshake, advance the model, then check all outputs.
   task automatic cycle();
      bit acc, cond, jal, jalr, inval, tk, rs;
      logic [W-1:0] sum, ca, fetched;
      #1;
      if (reset_n) chk("inReady", inReady, !m_valid || outReady);
      acc   = inValid && (!m_valid || outReady) && !flush;
      cond  = !isJAL && !isJALR;
      jal   = isJAL && !isJALR;
      jalr  = isJALR && !isJAL;
      inval = isJAL && isJALR;
      case (funct3)
         3'b000: tk = (src1 == src2);
         3'b001: tk = (src1 != src2);
         3'b100: tk = ($signed(src1) <  $signed(src2));
         3'b101: tk = ($signed(src1) >= $signed(src2));
         3'b110: tk = (src1 < src2);
         3'b111: tk = (src1 >= src2);
         default: tk = 0;
      endcase
      sum = src1 + src2;
      if (inval)      ca = nxtPC;
      else if (jal)   ca = targetAddress;
      else if (jalr)  ca = sum & ~32'd1;
      else            ca = tk ? targetAddress : nxtPC;
      fetched = redirect ? predictedPC : nxtPC;
      rs = !inval && (ca != fetched);

      if (!reset_n) begin
         model_zero();
      end else begin
         if (flush) m_valid = 0;
         else if (acc) m_valid = 1;
         else if (outReady) m_valid = 0;
         if (acc) begin
            m_tag = tagIn;
            m_ca  = ca;
            m_br  = nxtPC;
            m_rst = rs;
            m_tk  = (jal || jalr) ? 1'b1 : (cond && tk);
            m_wb  = cond ? (tk || redirect) : jalr;
            m_bv  = !(cond && !tk && redirect);
            m_up  = cond;
            m_ns  = cond ? sat_step(int'(state), tk, CW) : int'(state);
            m2_ns = cond ? sat_step(int'(state2), tk, CW2) : int'(state2);
         end
         if (perfClear) begin
            m_bc = 0; m_mc = 0; m2_bc = 0; m2_mc = 0;
         end else if (acc) begin
            if (cond) begin
               m_bc  = (m_bc  < (1 << NW)  - 1) ? m_bc + 1  : m_bc;
               m2_bc = (m2_bc < (1 << NW2) - 1) ? m2_bc + 1 : m2_bc;
            end
            if (rs) begin
               m_mc  = (m_mc  < (1 << NW)  - 1) ? m_mc + 1  : m_mc;
               m2_mc = (m2_mc < (1 << NW2) - 1) ? m2_mc + 1 : m2_mc;
            end
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_op(input logic [2:0] f3, input logic jal, input logic jalr,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] tgt, input logic [W-1:0] nxt,
                         input logic [W-1:0] pred, input logic redir,
                         input int st, input int st2);
      inValid = 1; funct3 = f3; isJAL = jal; isJALR = jalr;
      src1 = a; src2 = b; targetAddress = tgt; nxtPC = nxt; predictedPC = pred;
      redirect = redir; state = CW'(st); state2 = CW2'(st2); tagIn = TW'($urandom);
   endtask

   initial begin
      logic [W-1:0] frozen_ca;
      int r;
      reset_n = 0; flush = 0; inValid = 0; outReady = 1; perfClear = 0;
      isJAL = 0; isJALR = 0; redirect = 0; funct3 = '0; state = '0; state2 = '0;
      src1 = '0; src2 = '0; targetAddress = '0; nxtPC = '0; predictedPC = '0; tagIn = '0;
      model_zero();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_all();
      reset_n = 1;
      cycle();
      chk("inReady_after_reset", inReady, 1'b1);

      // BEQ taken, not predicted
      set_op(3'b000, 0, 0, 32'd5, 32'd5, 32'h200, 32'h104, 32'h0, 0, 1, 1);
      cycle();
      chk("req039_valid", outValid, 1'b1);
      chk("req039_taken", takenBranch, 1'b1);
      chk("req039_ca", correctAddress, 32'h200);
      chk("req039_reset", rst_flag, 1'b1);
      chk("req039_ns", nextState, 2'b10);
      chk("req039_wbtb", writeBTB, 1'b1);

      // BLTU not taken but BTB redirected
      set_op(3'b110, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h108, 32'h300, 1, 2, 2);
      cycle();
      chk("req040_taken", takenBranch, 1'b0);
      chk("req040_ca", correctAddress, 32'h108);
      chk("req040_reset", rst_flag, 1'b1);
      chk("req040_btbv", btbValid, 1'b0);
      chk("req040_ns", nextState, 2'b01);

      // JALR correctly predicted
      set_op(3'b000, 0, 1, 32'h1001, 32'd4, 32'h0, 32'h10C, 32'h1004, 1, 3, 3);
      cycle();
      chk("req041_ca", correctAddress, 32'h1004);
      chk("req041_reset", rst_flag, 1'b0);
      chk("req041_wbtb", writeBTB, 1'b1);
      chk("req041_upd", updatePHT, 1'b0);

      // stall three cycles with a waiting op, then drain
      outReady = 0;
      frozen_ca = correctAddress;
      set_op(3'b001, 0, 0, 32'd1, 32'd2, 32'h500, 32'h110, 32'h0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("req042_inready", inReady, 1'b0);
         chk("req042_frozen", correctAddress, frozen_ca);
      end
      outReady = 1;
      cycle();
      chk("req042_next_ca", correctAddress, 32'h500);

      // wide-counter saturation in the CTR_W=3 instance, CNT_W=2 branch counter
      set_op(3'b000, 0, 0, 32'd7, 32'd7, 32'h600, 32'h114, 32'h600, 1, 3, 7);
      cycle();
      chk("req043_ns_top", d2_ns, 3'b111);
      set_op(3'b001, 0, 0, 32'd7, 32'd7, 32'h600, 32'h118, 32'h0, 0, 0, 0);
      cycle();
      chk("req043_ns_bot", d2_ns, 3'b000);
      inValid = 0; perfClear = 1;
      cycle();
      perfClear = 0;
      for (int i = 0; i < 5; i++) begin
         set_op(3'b000, 0, 0, 32'd1, 32'd2, 32'h700, 32'h120, 32'h0, 0, 1, 1);
         cycle();
      end
      chk("req043_bc_sat", d2_bc, 2'd3);

      // flush during a stall with a waiting op
      outReady = 0;
      set_op(3'b000, 0, 0, 32'd1, 32'd1, 32'h800, 32'h124, 32'h0, 0, 1, 1);
      cycle();
      flush = 1;
      cycle();
      flush = 0;
      chk("req044_flush_valid", outValid, 1'b0);
      cycle();
      cycle();
      reset_n = 0;
      cycle();
      chk("req044_rst_valid", outValid, 1'b0);
      chk("req044_rst_ca", correctAddress, 32'h0);
      chk("req044_rst_bc", branchCount, 16'h0);
      reset_n = 1; outReady = 1; inValid = 0;
      cycle();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 7);
         set_op(3'($urandom), r == 5 || r == 7, r == 6 || r == 7,
                ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 6)) - 32'd3,
                ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 6)) - 32'd3,
                W'($urandom), W'($urandom) & ~32'd3, 32'h0, 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) src2 = src1;
         case ($urandom_range(0, 3))
            0: predictedPC = targetAddress;
            1: predictedPC = (src1 + src2) & ~32'd1;
            2: predictedPC = nxtPC;
            default: predictedPC = W'($urandom);
         endcase
         inValid   = ($urandom_range(0, 9) < 8);
         outReady  = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 9) == 0);
         perfClear = ($urandom_range(0, 19) == 0);
         reset_n   = ($urandom_range(0, 49) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
